// File: rtl/s2_rr_arbiter_pkg.sv
// s2_rr_arbiter_pkg: shared types for the S2 round-robin arbiter
package s2_rr_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_e;
   typedef struct packed {logic d11, d10, d01, d00;} dat_t;
   typedef struct packed {logic b1, b0, a1, a0;} sel_t;
endpackage

// File: rtl/s2_rr_arbiter_rr_pick.sv
// s2_rr_arbiter_rr_pick: combinational round-robin winner search starting at ptr
module s2_rr_arbiter_rr_pick
   import s2_rr_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDW-1:0]   ptr_i,
   output logic [IDW-1:0]   win_o,
   output logic             vld_o
);
   logic [IDW-1:0] idx;
   // scan from the farthest position back to ptr so the nearest requester wins
   always_comb begin
      win_o = '0;
      vld_o = 1'b0;
      idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr_i) + k) % N_REQ);
         if (req_i[idx]) begin
            win_o = idx;
            vld_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/s2_rr_arbiter.sv
// s2_rr_arbiter: shares one S2 mux-flop cell between N_REQ requesters via round-robin sequencing
module s2_rr_arbiter
   import s2_rr_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDW = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               clr_ni,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [4*N_REQ-1:0] req_d_i,
   input  logic [4*N_REQ-1:0] req_sel_i,
   output logic [N_REQ-1:0]   gnt_o,
   output logic [3:0]         cell_d_o,
   output logic [3:0]         cell_sel_o,
   output logic               cell_clr_o,
   input  logic               cell_out_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic               rsp_data_o,
   output logic [IDW-1:0]     rsp_id_o
);
   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, win;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   dat_t           cell_d_q, cell_d_d;
   sel_t           cell_sel_q, cell_sel_d;
   logic           rsp_valid_q, rsp_valid_d, rsp_data_q, rsp_data_d, win_vld;

   s2_rr_arbiter_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
      .req_i(req_i),
      .ptr_i(ptr_q),
      .win_o(win),
      .vld_o(win_vld)
   );

   // sequencing: grant, let the cell register, capture its output, hand it off
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      gnt_d       = '0;
      cell_d_d    = cell_d_q;
      cell_sel_d  = cell_sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         IDLE: if (win_vld) begin
            gnt_d      = N_REQ'(1) << win;
            cell_d_d   = req_d_i[{win, 2'b00} +: 4];
            cell_sel_d = req_sel_i[{win, 2'b00} +: 4];
            id_d       = win;
            ptr_d      = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
            state_d    = DRIVE;
         end
         DRIVE: state_d = SAMPLE;
         SAMPLE: begin
            rsp_data_d  = cell_out_i;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge clr_ni) begin
      if (!clr_ni) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         gnt_q       <= '0;
         cell_d_q    <= '0;
         cell_sel_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         gnt_q       <= gnt_d;
         cell_d_q    <= cell_d_d;
         cell_sel_q  <= cell_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign cell_d_o    = cell_d_q;
   assign cell_sel_o  = cell_sel_q;
   assign cell_clr_o  = ~clr_ni;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_id_o    = rsp_id_q;
endmodule

// File: tb/tb_s2_rr_arbiter.sv
// tb_s2_rr_arbiter: scoreboard bench with an S2 cell model and a transaction-level arbiter model
module tb_s2_rr_arbiter;
   import s2_rr_arbiter_pkg::*;
   localparam int N = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0, clr = 1'b0, rsp_ready = 1'b0, cell_out;
   logic [N-1:0]   req = '0, gnt;
   logic [4*N-1:0] req_d = '0, req_sel = '0;
   logic [3:0]     cell_d, cell_sel;
   logic           cell_clr, rsp_valid, rsp_data;
   logic [IDW-1:0] rsp_id;

   int checks = 0, fails = 0, n_rsp = 0;
   typedef struct {int id; logic data;} rsp_t;
   rsp_t sb[$];
   int order_q[$];
   bit rec = 0;

   s2_rr_arbiter #(.N_REQ(N), .IDW(IDW)) dut (
      .clk(clk), .clr_ni(clr), .req_i(req), .req_d_i(req_d), .req_sel_i(req_sel),
      .gnt_o(gnt), .cell_d_o(cell_d), .cell_sel_o(cell_sel), .cell_clr_o(cell_clr),
      .cell_out_i(cell_out), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_data_o(rsp_data), .rsp_id_o(rsp_id)
   );

   always #5 clk = ~clk;

   function automatic logic s2_ref(logic [3:0] d, sel_t s);
      int row, col;
      row = (s.b0 | s.b1) ? 1 : 0;
      col = (s.a0 & s.a1) ? 1 : 0;
      return d[row * 2 + col];
   endfunction

   // S2 cell stand-in
   always_ff @(posedge clk or posedge cell_clr)
      if (cell_clr) cell_out <= 1'b0;
      else cell_out <= s2_ref(cell_d, cell_sel);

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // transaction-level model: busy from a grant until the response is taken
   int m_ptr, m_age;
   bit m_busy;
   logic [N-1:0] exp_gnt;
   logic exp_valid;
   logic [3:0] exp_cd, exp_cs;
   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         m_ptr = 0; m_age = 0; m_busy = 0;
         exp_gnt = '0; exp_valid = 0; exp_cd = '0; exp_cs = '0;
         sb.delete();
      end else begin
         exp_gnt = '0;
         if (m_busy) begin
            m_age++;
            if (m_age >= 3 && rsp_ready) m_busy = 0;
         end else if (|req) begin
            int w;
            bit found;
            w = 0; found = 0;
            for (int k = 0; k < N; k++)
               if (!found && req[(m_ptr + k) % N]) begin w = (m_ptr + k) % N; found = 1; end
            exp_gnt = N'(1) << w;
            exp_cd = req_d[4*w +: 4];
            exp_cs = req_sel[4*w +: 4];
            sb.push_back('{w, s2_ref(exp_cd, exp_cs)});
            m_ptr = (w + 1) % N;
            m_busy = 1;
            m_age = 0;
         end
         exp_valid = m_busy && m_age >= 2;
      end
   end

   // monitor on the falling edge
   bit prev_v = 0;
   logic prev_data;
   logic [IDW-1:0] prev_id;
   always @(negedge clk) begin
      chk("cell_clr", cell_clr, !clr);
      if (!clr) begin
         chk("rst_gnt", gnt, 0);
         chk("rst_valid", rsp_valid, 0);
         chk("rst_data", rsp_data, 0);
         chk("rst_id", rsp_id, 0);
         chk("rst_cell_d", cell_d, 0);
         chk("rst_cell_sel", cell_sel, 0);
         prev_v = 0;
      end else begin
         chk("gnt", gnt, exp_gnt);
         chk("rsp_valid", rsp_valid, exp_valid);
         chk("cell_d", cell_d, exp_cd);
         chk("cell_sel", cell_sel, exp_cs);
         if (rec && gnt != 0)
            for (int i = 0; i < N; i++) if (gnt[i]) order_q.push_back(i);
         if (rsp_valid && prev_v) begin
            chk("hold_data", rsp_data, prev_data);
            chk("hold_id", rsp_id, prev_id);
         end
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL sb_empty: response id %0d with nothing expected", rsp_id);
            end else begin
               rsp_t e;
               e = sb.pop_front();
               chk("rsp_id", rsp_id, e.id);
               chk("rsp_data", rsp_data, e.data);
            end
         end
         prev_v = rsp_valid && !rsp_ready;
         prev_data = rsp_data;
         prev_id = rsp_id;
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt();
      int n;
      n = 0;
      while (gnt == 0 && n < 20) begin tick(1); n++; end
      chk("gnt_timeout", n < 20, 1);
   endtask

   initial begin
      int n;
      req = '1; rsp_ready = 1;
      tick(3);
      clr = 1; rec = 1;
      tick(22);
      rec = 0; req = '0;
      chk("rr_count", order_q.size() >= 5, 1);
      if (order_q.size() >= 5)
         for (int i = 0; i < 5; i++) chk("rr_order", order_q[i], i % N);
      tick(6);
      req = 4'b0100;
      req_d[11:8] = 4'b1000;
      req_sel[11:8] = 4'b0111;
      wait_gnt();
      chk("single_gnt", gnt, 4'b0100);
      req = '0;
      n = 0;
      while (!rsp_valid && n < 10) begin tick(1); n++; end
      chk("latency", n, 2);
      chk("single_data", rsp_data, 1);
      chk("single_id", rsp_id, 2);
      tick(3);
      req = 4'b0011;
      wait_gnt();
      chk("wrap_gnt0", gnt, 4'b0001);
      tick(1);
      wait_gnt();
      chk("wrap_gnt1", gnt, 4'b0010);
      req = '0;
      tick(6);
      rsp_ready = 0; req = '1;
      tick(12);
      rsp_ready = 1;
      tick(8);
      req = '1;
      wait_gnt();
      tick(1);
      clr = 0;
      tick(2);
      chk("midrst_valid", rsp_valid, 0);
      clr = 1;
      wait_gnt();
      chk("midrst_gnt", gnt, 4'b0001);
      for (int i = 0; i < 600; i++) begin
         req = N'($urandom & $urandom);
         req_d = 16'($urandom);
         req_sel = 16'($urandom);
         rsp_ready = $urandom_range(0, 3) != 0;
         tick(1);
      end
      req = '0; rsp_ready = 1;
      tick(8);
      chk("sb_drain", sb.size(), 0);
      chk("rsp_seen", n_rsp > 20, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
